// File: rtl/relu_wb_sched.sv
// relu_wb_sched: write-back scheduler behind the ReLU stage.
// Captures CO-channel ReLU words into a DEPTH-entry FIFO and serialises
// them one channel per beat onto a valid/ready write port with a
// channel-major feature-map address (ch*OW*OH + pix).
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   start             one-cycle pulse starting a pass (IDLE only)
//   relu_valid/out    incoming pixel word, channel c at [c*AB_BW +: AB_BW]
//   wb_valid/ready    write-port handshake
//   wb_data/addr      channel value and its feature-map address
//   busy, done        pass in progress / one-cycle end-of-pass pulse
//   overflow          sticky: a word was dropped during this pass
module relu_wb_sched #(
  parameter int CO      = 16,
  parameter int AB_BW   = 32,
  parameter int OW      = 8,
  parameter int OH      = 8,
  parameter int DEPTH   = 4,
  parameter int ADDR_BW = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  relu_valid,
  input  logic [CO*AB_BW-1:0]   relu_out,
  output logic                  wb_valid,
  input  logic                  wb_ready,
  output logic [AB_BW-1:0]      wb_data,
  output logic [ADDR_BW-1:0]    wb_addr,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow
);
  localparam int NPIX  = OW * OH;
  localparam int CH_W  = (CO > 1) ? $clog2(CO) : 1;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  typedef logic [CO-1:0][AB_BW-1:0] word_t;

  state_t              state_q, state_d;
  word_t               mem_q [DEPTH];
  word_t               mem_d [DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_BW:0]    in_cnt_q, in_cnt_d;  // one extra bit: reaches NPIX
  logic [ADDR_BW-1:0]  pix_q, pix_d;
  logic [CH_W-1:0]     ch_q, ch_d;
  logic                ovf_q, ovf_d;

  logic run, full, empty, accept, last_ch, pop, push, drop, room;

  assign run     = (state_q == RUN);
  assign full    = (cnt_q == CNT_W'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign last_ch = (ch_q == CH_W'(CO - 1));
  assign accept  = wb_valid && wb_ready;
  assign pop     = accept && last_ch;
  // A full FIFO still takes a word when its head retires this cycle.
  assign room    = (in_cnt_q < (ADDR_BW + 1)'(NPIX)) && (!full || pop);
  assign push    = run && relu_valid && room;
  assign drop    = run && relu_valid && !room;

  // Outputs are gated by wb_valid so they read 0 whenever no beat is offered.
  assign wb_valid = run && !empty;
  assign wb_data  = wb_valid ? mem_q[rd_ptr_q][ch_q] : '0;
  assign wb_addr  = wb_valid ? (ADDR_BW'(ch_q) * ADDR_BW'(NPIX) + pix_q) : '0;
  assign busy     = run;
  assign done     = (state_q == DONE);
  assign overflow = ovf_q;

  always_comb begin
    state_d  = state_q;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    in_cnt_d = in_cnt_q;
    pix_d    = pix_q;
    ch_d     = ch_q;
    ovf_d    = ovf_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = RUN;
          wr_ptr_d = '0;
          rd_ptr_d = '0;
          cnt_d    = '0;
          in_cnt_d = '0;
          pix_d    = '0;
          ch_d     = '0;
          ovf_d    = 1'b0;
        end
      end
      RUN: begin
        if (accept) begin
          if (last_ch) begin
            ch_d     = '0;
            pix_d    = pix_q + 1'b1;
            rd_ptr_d = rd_ptr_q + 1'b1;
            if (pix_q == ADDR_BW'(NPIX - 1)) state_d = DONE;
          end else begin
            ch_d = ch_q + 1'b1;
          end
        end
        // Write slot may equal the head being popped; the head is read
        // combinationally this cycle, so overwriting at the edge is safe.
        if (push) begin
          mem_d[wr_ptr_q] = word_t'(relu_out);
          wr_ptr_d        = wr_ptr_q + 1'b1;
          in_cnt_d        = in_cnt_q + 1'b1;
        end
        case ({push, pop})
          2'b10:   cnt_d = cnt_q + 1'b1;
          2'b01:   cnt_d = cnt_q - 1'b1;
          default: cnt_d = cnt_q;
        endcase
        if (drop) ovf_d = 1'b1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      in_cnt_q <= '0;
      pix_q    <= '0;
      ch_q     <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      in_cnt_q <= in_cnt_d;
      pix_q    <= pix_d;
      ch_q     <= ch_d;
      ovf_q    <= ovf_d;
    end
  end
endmodule
